// File: rtl/fft_stage_sequencer_pkg.sv
// rtl/fft_stage_sequencer_pkg.sv - shared types and helpers for the FFT stage sequencer
package fft_ctrl_pkg;

    typedef enum logic {IDLE, RUN} seq_state_t;

    function automatic int stage_off(input int s, input int lat);
        return s * lat;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - frame request inputs and per-stage timing outputs
interface fft_stage_sequencer_if #(
    parameter int N_STAGE = 3,
    parameter int N_BLK   = 4
);
    logic                   start;
    logic                   abort;
    logic [N_STAGE-1:0]     en_stage;
    logic [N_STAGE-1:0]     valid_stage;
    logic [$clog2(N_BLK):0] blk_idx;
    logic                   busy;
    logic                   done;
    logic                   start_err;

    modport master (
        input  start, abort,
        output en_stage, valid_stage, blk_idx, busy, done, start_err
    );

    modport slave (
        output start, abort,
        input  en_stage, valid_stage, blk_idx, busy, done, start_err
    );
endinterface

// File: rtl/fft_stage_sequencer_decode.sv
// rtl/fft_stage_sequencer_decode.sv - block-start and second-half window decode for one stage
module stage_window_decode #(
    parameter int OFFSET  = 0,
    parameter int BLK_LEN = 16,
    parameter int N_BLK   = 4,
    parameter int T_W     = 7
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [T_W-1:0] t_next,
    input  logic           run_next,
    output logic           en,
    output logic           valid
);
    localparam int             LOG_BLK = $clog2(BLK_LEN);
    localparam logic [T_W-1:0] START_T = T_W'(OFFSET);
    localparam logic [T_W-1:0] FRAME_T = T_W'(N_BLK * BLK_LEN);

    logic [T_W-1:0]     l;
    logic [LOG_BLK-1:0] phase;
    logic               active;

    // Before the stage offset the subtraction wraps above FRAME_T, so one compare covers both ends.
    assign l      = t_next - START_T;
    assign phase  = l[LOG_BLK-1:0];
    assign active = run_next && (l < FRAME_T);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en    <= 1'b0;
            valid <= 1'b0;
        end else begin
            en    <= active && (phase == '0);
            valid <= active && phase[LOG_BLK-1];
        end
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - frame sequencer driving staggered block timing for the FFT stages
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int N_STAGE   = 3,
    parameter int BLK_LEN   = 16,
    parameter int N_BLK     = 4,
    parameter int STAGE_LAT = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    fft_stage_sequencer_if.master seq
);
    localparam int FRAME_LEN = N_BLK * BLK_LEN;
    localparam int T_END     = (N_STAGE - 1) * STAGE_LAT + FRAME_LEN;
    localparam int T_W       = $clog2(T_END + 1);
    localparam int LOG_BLK   = $clog2(BLK_LEN);
    localparam int BI_W      = $clog2(N_BLK) + 1;

    localparam logic [T_W-1:0] T_LAST  = T_W'(T_END);
    localparam logic [T_W-1:0] FRAME_T = T_W'(FRAME_LEN);

    seq_state_t          state, state_next;
    logic [T_W-1:0]      t, t_next;
    logic                run_next;
    logic                at_end;
    logic [BI_W-1:0]     blk_next;
    logic [N_STAGE-1:0]  en_w, valid_w;
    logic [BI_W-1:0]     blk_q;
    logic                busy_q, done_q, start_err_q;

    assign at_end = (state == RUN) && (t == T_LAST);

    always_comb begin
        state_next = state;
        t_next     = t;
        if (seq.abort) begin
            state_next = IDLE;
            t_next     = '0;
        end else if (state == IDLE) begin
            if (seq.start) begin
                state_next = RUN;
                t_next     = '0;
            end
        end else if (at_end) begin
            state_next = seq.start ? RUN : IDLE;
            t_next     = '0;
        end else begin
            t_next = t + T_W'(1);
        end
    end

    assign run_next = (state_next == RUN);

    always_comb begin
        blk_next = '0;
        if (run_next) begin
            if (t_next < FRAME_T)
                blk_next = BI_W'(t_next >> LOG_BLK);
            else
                blk_next = BI_W'(N_BLK - 1);
        end
    end

    // All outputs are taken from the next-state so they line up with the cycle carrying that t.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            t           <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            blk_q       <= '0;
        end else begin
            state       <= state_next;
            t           <= t_next;
            busy_q      <= run_next;
            done_q      <= run_next && (t_next == T_LAST);
            start_err_q <= (state == RUN) && !at_end && seq.start && !seq.abort;
            blk_q       <= blk_next;
        end
    end

    for (genvar s = 0; s < N_STAGE; s++) begin : g_stage
        stage_window_decode #(
            .OFFSET  (stage_off(s, STAGE_LAT)),
            .BLK_LEN (BLK_LEN),
            .N_BLK   (N_BLK),
            .T_W     (T_W)
        ) u_decode (
            .clk      (clk),
            .rstn     (rstn),
            .t_next   (t_next),
            .run_next (run_next),
            .en       (en_w[s]),
            .valid    (valid_w[s])
        );
    end

    assign seq.en_stage    = en_w;
    assign seq.valid_stage = valid_w;
    assign seq.blk_idx     = blk_q;
    assign seq.busy        = busy_q;
    assign seq.done        = done_q;
    assign seq.start_err   = start_err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.N_STAGE(3), .N_BLK(4)) sif ();
    fft_stage_sequencer_if #(.N_STAGE(1), .N_BLK(1)) sif_s ();

    fft_stage_sequencer #(
        .N_STAGE(3), .BLK_LEN(16), .N_BLK(4), .STAGE_LAT(8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .seq  (sif.master)
    );

    fft_stage_sequencer #(
        .N_STAGE(1), .BLK_LEN(2), .N_BLK(1), .STAGE_LAT(1)
    ) dut_s (
        .clk  (clk),
        .rstn (rstn),
        .seq  (sif_s.master)
    );

    // Expected {en[2:0], valid[2:0], busy, done, blk_idx[2:0], start_err} at frame time t.
    function automatic logic [11:0] exp_vec(input int t, input logic serr);
        logic [2:0] en, vl, blk;
        int         l;
        en = '0;
        vl = '0;
        if (t < 0 || t > 80) return {11'h0, serr};
        for (int s = 0; s < 3; s++) begin
            l = t - 8 * s;
            if (l >= 0 && l < 64) begin
                en[s] = (l % 16) == 0;
                vl[s] = (l % 16) >= 8;
            end
        end
        blk = (t < 64) ? 3'(t / 16) : 3'd3;
        return {en, vl, 1'b1, (t == 80), blk, serr};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {sif.en_stage, sif.valid_stage, sif.busy, sif.done, sif.blk_idx, sif.start_err};
    endfunction

    task automatic test_reset();
        rstn        = 1'b0;
        sif.start   = 1'b0;
        sif.abort   = 1'b0;
        sif_s.start = 1'b0;
        sif_s.abort = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_vec() !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_main got %h want %h", obs_vec(), 12'h0);
        end
        n_chk++;
        if ({sif_s.en_stage, sif_s.valid_stage, sif_s.busy, sif_s.done, sif_s.blk_idx, sif_s.start_err} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_small got %b want 000000",
                     {sif_s.en_stage, sif_s.valid_stage, sif_s.busy, sif_s.done, sif_s.blk_idx, sif_s.start_err});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_vec() !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_idle got %h want %h", obs_vec(), 12'h0);
        end
    endtask

    task automatic test_single_frame();
        logic [11:0] want;
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        for (int t = 0; t <= 82; t++) begin
            want = exp_vec(t, 1'b0);
            n_chk++;
            if (obs_vec() !== want) begin
                n_fail++;
                $display("FAIL single_frame t=%0d got %h want %h", t, obs_vec(), want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk);
        for (int t = 0; t <= 80; t++) begin
            n_chk++;
            if ({sif.busy, sif.done} !== {1'b1, (t == 80)}) begin
                n_fail++;
                $display("FAIL b2b_frame1 t=%0d busy_done got %b want %b", t, {sif.busy, sif.done}, {1'b1, (t == 80)});
            end
            @(negedge clk);
        end
        sif.start = 1'b0;
        n_chk++;
        if (obs_vec() !== exp_vec(0, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_restart got %h want %h", obs_vec(), exp_vec(0, 1'b0));
        end
        @(negedge clk);
        for (int t = 1; t <= 82; t++) begin
            n_chk++;
            if (obs_vec() !== exp_vec(t, 1'b0)) begin
                n_fail++;
                $display("FAIL b2b_frame2 t=%0d got %h want %h", t, obs_vec(), exp_vec(t, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_err();
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        for (int t = 0; t <= 82; t++) begin
            n_chk++;
            if (obs_vec() !== exp_vec(t, (t == 31))) begin
                n_fail++;
                $display("FAIL start_err t=%0d got %h want %h", t, obs_vec(), exp_vec(t, (t == 31)));
            end
            sif.start = (t == 30);
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        logic seen;
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            n_chk++;
            if (obs_vec() !== exp_vec(t, 1'b0)) begin
                n_fail++;
                $display("FAIL abort_pre t=%0d got %h want %h", t, obs_vec(), exp_vec(t, 1'b0));
            end
            if (t < 40) @(negedge clk);
        end
        sif.abort = 1'b1;
        sif.start = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        sif.start = 1'b0;
        n_chk++;
        if (obs_vec() !== 12'h0) begin
            n_fail++;
            $display("FAIL abort_clear got %h want %h", obs_vec(), 12'h0);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sif.busy || sif.done) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle got busy_or_done=%b want 0", seen);
        end
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        for (int t = 0; t <= 81; t++) begin
            n_chk++;
            if (obs_vec() !== exp_vec(t, 1'b0)) begin
                n_fail++;
                $display("FAIL abort_new_frame t=%0d got %h want %h", t, obs_vec(), exp_vec(t, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (obs_vec() !== exp_vec(20, 1'b0)) begin
            n_fail++;
            $display("FAIL areset_pre got %h want %h", obs_vec(), exp_vec(20, 1'b0));
        end
        rstn = 1'b0;
        #1;
        n_chk++;
        if (obs_vec() !== 12'h0) begin
            n_fail++;
            $display("FAIL areset_immediate got %h want %h", obs_vec(), 12'h0);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_vec() !== 12'h0) begin
                n_fail++;
                $display("FAIL areset_idle i=%0d got %h want %h", i, obs_vec(), 12'h0);
            end
        end
    endtask

    task automatic test_small_params();
        logic [5:0] want [0:4];
        want[0] = 6'b1_0_1_0_0_0;
        want[1] = 6'b0_1_1_0_0_0;
        want[2] = 6'b0_0_1_1_0_0;
        want[3] = 6'b0_0_0_0_0_0;
        want[4] = 6'b0_0_0_0_0_0;
        @(negedge clk) sif_s.start = 1'b1;
        @(negedge clk) sif_s.start = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            n_chk++;
            if ({sif_s.en_stage, sif_s.valid_stage, sif_s.busy, sif_s.done, sif_s.blk_idx, sif_s.start_err} !== want[t]) begin
                n_fail++;
                $display("FAIL small_params t=%0d got %b want %b", t,
                         {sif_s.en_stage, sif_s.valid_stage, sif_s.busy, sif_s.done, sif_s.blk_idx, sif_s.start_err}, want[t]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_start_err();
        test_abort();
        test_async_reset();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
